// File: rtl/avalon_dpram_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : avalon_dpram_pipe_if
// Brief    : Avalon-MM slave port bundle for one side of avalon_dpram_pipe.
// Revision : 1.0 - initial release
// ============================================================================
interface avalon_dpram_pipe_if #(
  parameter int WIDTHA = 10,
  parameter int WIDTHD = 32
);
  logic [WIDTHA-1:0]   address;
  logic [WIDTHD-1:0]   writedata;
  logic [WIDTHD/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [WIDTHD-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;

  modport master (
    output address, writedata, byteenable, read, write,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, writedata, byteenable, read, write,
    output readdata, readdatavalid, waitrequest
  );
endinterface
`default_nettype wire

// File: rtl/avalon_dpram_pipe.sv
`default_nettype none
// ============================================================================
// Module   : avalon_dpram_pipe
// Brief    : True dual-port RAM, two Avalon-MM slaves, pipelined reads,
//            byte enables, fair same-address write arbitration.
//            Optional macro AVALON_DPRAM_BYPASS_EN: cross-port write forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module avalon_dpram_pipe #(
  parameter int    WIDTHA = 10,
  parameter int    WIDTHD = 32,
  parameter int    RDLAT  = 1,
  parameter string FILE   = ""
) (
  input  wire logic          clock,
  input  wire logic          areset_n,
  avalon_dpram_pipe_if.slave a,
  avalon_dpram_pipe_if.slave b
);
  localparam int c_DEPTH = 2 ** WIDTHA;
  localparam int c_NBYTE = WIDTHD / 8;

  logic [WIDTHD-1:0] r_mem [c_DEPTH];

  logic              r_prio_b;
  logic              w_collision;
  logic              w_a_wr_acc;
  logic              w_b_wr_acc;
  logic              w_a_rd_acc;
  logic              w_b_rd_acc;
  logic [WIDTHD-1:0] w_a_rd_word;
  logic [WIDTHD-1:0] w_b_rd_word;

  logic [WIDTHD-1:0] r_a_data [RDLAT];
  logic [WIDTHD-1:0] r_b_data [RDLAT];
  logic [RDLAT-1:0]  r_a_vld;
  logic [RDLAT-1:0]  r_b_vld;

  // Only writes can collide; the loser of a collision alternates via r_prio_b.
  assign w_collision = a.write && b.write && (a.address == b.address);
  assign w_a_wr_acc  = a.write && !(w_collision && r_prio_b);
  assign w_b_wr_acc  = b.write && !(w_collision && !r_prio_b);
  assign w_a_rd_acc  = a.read && !a.write;
  assign w_b_rd_acc  = b.read && !b.write;

  assign a.waitrequest = w_collision && r_prio_b;
  assign b.waitrequest = w_collision && !r_prio_b;

  always_ff @(posedge clock) begin
    for (int k = 0; k < c_NBYTE; k++) begin
      if (w_a_wr_acc && a.byteenable[k])
        r_mem[a.address][k*8 +: 8] <= a.writedata[k*8 +: 8];
      if (w_b_wr_acc && b.byteenable[k])
        r_mem[b.address][k*8 +: 8] <= b.writedata[k*8 +: 8];
    end
  end

  always_comb begin
    w_a_rd_word = r_mem[a.address];
    w_b_rd_word = r_mem[b.address];
`ifdef AVALON_DPRAM_BYPASS_EN
    for (int k = 0; k < c_NBYTE; k++) begin
      if (w_b_wr_acc && (b.address == a.address) && b.byteenable[k])
        w_a_rd_word[k*8 +: 8] = b.writedata[k*8 +: 8];
      if (w_a_wr_acc && (a.address == b.address) && a.byteenable[k])
        w_b_rd_word[k*8 +: 8] = a.writedata[k*8 +: 8];
    end
`endif
  end

  // Data stages load only behind a valid bit so readdata holds between pulses.
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      r_prio_b <= 1'b0;
      r_a_vld  <= '0;
      r_b_vld  <= '0;
      for (int s = 0; s < RDLAT; s++) begin
        r_a_data[s] <= '0;
        r_b_data[s] <= '0;
      end
    end else begin
      if (w_collision)
        r_prio_b <= !r_prio_b;
      else if (w_b_wr_acc)
        r_prio_b <= 1'b0;

      r_a_vld[0] <= w_a_rd_acc;
      r_b_vld[0] <= w_b_rd_acc;
      if (w_a_rd_acc)
        r_a_data[0] <= w_a_rd_word;
      if (w_b_rd_acc)
        r_b_data[0] <= w_b_rd_word;

      for (int s = 1; s < RDLAT; s++) begin
        r_a_vld[s] <= r_a_vld[s-1];
        r_b_vld[s] <= r_b_vld[s-1];
        if (r_a_vld[s-1])
          r_a_data[s] <= r_a_data[s-1];
        if (r_b_vld[s-1])
          r_b_data[s] <= r_b_data[s-1];
      end
    end
  end

  assign a.readdata      = r_a_data[RDLAT-1];
  assign a.readdatavalid = r_a_vld[RDLAT-1];
  assign b.readdata      = r_b_data[RDLAT-1];
  assign b.readdatavalid = r_b_vld[RDLAT-1];

endmodule
`default_nettype wire

// File: tb/tb_avalon_dpram_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_dpram_pipe
// Brief    : Self-checking bench for avalon_dpram_pipe (RDLAT=3, 64 words).
// Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_dpram_pipe;
  localparam int c_WA  = 6;
  localparam int c_WD  = 32;
  localparam int c_LAT = 3;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  logic clock;
  logic areset_n;

  avalon_dpram_pipe_if #(.WIDTHA(c_WA), .WIDTHD(c_WD)) a_if ();
  avalon_dpram_pipe_if #(.WIDTHA(c_WA), .WIDTHD(c_WD)) b_if ();

  avalon_dpram_pipe #(
    .WIDTHA(c_WA), .WIDTHD(c_WD), .RDLAT(c_LAT), .FILE("")
  ) dut (
    .clock    (clock),
    .areset_n (areset_n),
    .a        (a_if),
    .b        (b_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          m_prio = 1'b0;
  logic [31:0] ref_mem [64];
  rd_t         qa[$];
  rd_t         qb[$];
  logic [31:0] exp_last_a = '0;
  logic [31:0] exp_last_b = '0;
  int          a_vld_cnt = 0, b_vld_cnt = 0;
  int          obs_a_cyc = 0, obs_b_cyc = 0;
  logic [31:0] obs_a_data = '0, obs_b_data = '0;
  int          dut_a_done = 0, dut_b_done = 0;
  logic        seen_aw, seen_bw;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int k = 0; k < 4; k++)
      if (be[k]) r[k*8 +: 8] = new_w[k*8 +: 8];
    return r;
  endfunction

  task automatic drive(input bit port_b, input logic rd, input logic wr, input logic [5:0] adr,
                       input logic [31:0] wd, input logic [3:0] be);
    if (port_b) begin
      b_if.read = rd; b_if.write = wr; b_if.address = adr;
      b_if.writedata = wd; b_if.byteenable = be;
    end else begin
      a_if.read = rd; a_if.write = wr; a_if.address = adr;
      a_if.writedata = wd; a_if.byteenable = be;
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // One clock cycle: predict from the request, clock it, compare outputs.
  task automatic step();
    logic        coll, a_w, b_w;
    logic [31:0] a_rd, b_rd;
    rd_t         e;
    bit          ev;
    #1;
    coll    = a_if.write && b_if.write && (a_if.address == b_if.address);
    seen_aw = a_if.waitrequest;
    seen_bw = b_if.waitrequest;
    checks += 2;
    if (a_if.waitrequest !== (coll && m_prio)) begin
      errors++;
      $display("FAIL a_waitrequest cyc %0d: got %b expected %b", cyc, a_if.waitrequest, coll && m_prio);
    end
    if (b_if.waitrequest !== (coll && !m_prio)) begin
      errors++;
      $display("FAIL b_waitrequest cyc %0d: got %b expected %b", cyc, b_if.waitrequest, coll && !m_prio);
    end
    if (a_if.write && !a_if.waitrequest) dut_a_done++;
    if (b_if.write && !b_if.waitrequest) dut_b_done++;

    a_w  = a_if.write && !(coll && m_prio);
    b_w  = b_if.write && !(coll && !m_prio);
    a_rd = ref_mem[a_if.address];
    b_rd = ref_mem[b_if.address];
`ifdef AVALON_DPRAM_BYPASS_EN
    if (b_w && b_if.address == a_if.address) a_rd = merge(a_rd, b_if.writedata, b_if.byteenable);
    if (a_w && a_if.address == b_if.address) b_rd = merge(b_rd, a_if.writedata, a_if.byteenable);
`endif
    if (a_if.read && !a_if.write) begin e.due = cyc + c_LAT; e.data = a_rd; qa.push_back(e); end
    if (b_if.read && !b_if.write) begin e.due = cyc + c_LAT; e.data = b_rd; qb.push_back(e); end
    if (a_w) ref_mem[a_if.address] = merge(ref_mem[a_if.address], a_if.writedata, a_if.byteenable);
    if (b_w) ref_mem[b_if.address] = merge(ref_mem[b_if.address], b_if.writedata, b_if.byteenable);
    if (coll) m_prio = !m_prio;
    else if (b_w) m_prio = 1'b0;

    @(posedge clock);
    #1;
    cyc++;

    ev = (qa.size() > 0) && (qa[0].due == cyc);
    if (ev) begin exp_last_a = qa[0].data; void'(qa.pop_front()); end
    checks += 2;
    if (a_if.readdatavalid !== ev) begin
      errors++;
      $display("FAIL a_readdatavalid cyc %0d: got %b expected %b", cyc, a_if.readdatavalid, ev);
    end
    if (a_if.readdata !== exp_last_a) begin
      errors++;
      $display("FAIL a_readdata cyc %0d: got %h expected %h", cyc, a_if.readdata, exp_last_a);
    end
    if (a_if.readdatavalid === 1'b1) begin a_vld_cnt++; obs_a_cyc = cyc; obs_a_data = a_if.readdata; end

    ev = (qb.size() > 0) && (qb[0].due == cyc);
    if (ev) begin exp_last_b = qb[0].data; void'(qb.pop_front()); end
    checks += 2;
    if (b_if.readdatavalid !== ev) begin
      errors++;
      $display("FAIL b_readdatavalid cyc %0d: got %b expected %b", cyc, b_if.readdatavalid, ev);
    end
    if (b_if.readdata !== exp_last_b) begin
      errors++;
      $display("FAIL b_readdata cyc %0d: got %h expected %h", cyc, b_if.readdata, exp_last_b);
    end
    if (b_if.readdatavalid === 1'b1) begin b_vld_cnt++; obs_b_cyc = cyc; obs_b_data = b_if.readdata; end
  endtask

  task automatic test_reset();
    areset_n = 1'b0;
    idle();
    #3;
    checks += 4;
    if (a_if.readdata !== '0 || a_if.readdatavalid !== 1'b0) begin
      errors++; $display("FAIL reset_a: got %h/%b expected 0/0", a_if.readdata, a_if.readdatavalid);
    end
    if (b_if.readdata !== '0 || b_if.readdatavalid !== 1'b0) begin
      errors++; $display("FAIL reset_b: got %h/%b expected 0/0", b_if.readdata, b_if.readdatavalid);
    end
    if (a_if.waitrequest !== 1'b0) begin
      errors++; $display("FAIL reset_a_wait: got %b expected 0", a_if.waitrequest);
    end
    if (b_if.waitrequest !== 1'b0) begin
      errors++; $display("FAIL reset_b_wait: got %b expected 0", b_if.waitrequest);
    end
    @(posedge clock); @(posedge clock);
    #1;
    areset_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 1'b1, 6'(2*i),   $urandom, 4'hf);
      drive(1'b1, 1'b0, 1'b1, 6'(2*i+1), $urandom, 4'hf);
      step();
    end
    idle();
    step();
  endtask

  task automatic test_latency();
    int t, n0;
    drive(1'b0, 1'b0, 1'b1, 6'd5, 32'hDEADBEEF, 4'hf);
    step();
    n0 = a_vld_cnt;
    t  = cyc;
    drive(1'b0, 1'b1, 1'b0, 6'd5, '0, '0);
    step();
    idle();
    for (int i = 0; i < 5; i++) step();
    checks += 3;
    if (obs_a_cyc !== t + 3) begin
      errors++; $display("FAIL latency_cycle: got %0d expected %0d", obs_a_cyc, t + 3);
    end
    if (obs_a_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL latency_data: got %h expected deadbeef", obs_a_data);
    end
    if (a_vld_cnt - n0 !== 1) begin
      errors++; $display("FAIL latency_pulses: got %0d expected 1", a_vld_cnt - n0);
    end
  endtask

  task automatic test_back_to_back();
    int t, n0;
    n0 = b_vld_cnt;
    t  = cyc;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 6'(i), '0, '0);
      step();
    end
    idle();
    for (int i = 0; i < 5; i++) step();
    checks += 2;
    if (b_vld_cnt - n0 !== 8) begin
      errors++; $display("FAIL b2b_count: got %0d expected 8", b_vld_cnt - n0);
    end
    if (obs_b_cyc !== t + 7 + c_LAT) begin
      errors++; $display("FAIL b2b_last_cycle: got %0d expected %0d", obs_b_cyc, t + 7 + c_LAT);
    end
  endtask

  task automatic test_byteenable();
    drive(1'b0, 1'b0, 1'b1, 6'd9, 32'h11223344, 4'hf);
    step();
    drive(1'b0, 1'b0, 1'b1, 6'd9, 32'hAABBCCDD, 4'b0101);
    step();
    drive(1'b0, 1'b1, 1'b0, 6'd9, '0, '0);
    step();
    idle();
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (obs_a_data !== 32'h11BB33DD) begin
      errors++; $display("FAIL byteenable: got %h expected 11bb33dd", obs_a_data);
    end
  endtask

  task automatic test_collision();
    int a0, b0;
    a0 = dut_a_done;
    b0 = dut_b_done;
    for (int n = 0; n < 4; n++) begin
      drive(1'b0, 1'b0, 1'b1, 6'd2, 32'(8'hA0 + n), 4'hf);
      drive(1'b1, 1'b0, 1'b1, 6'd2, 32'(8'hB0 + n), 4'hf);
      step();
      checks += 2;
      if (seen_bw !== ((n % 2) == 0)) begin
        errors++; $display("FAIL collision_b_wait n=%0d: got %b expected %b", n, seen_bw, (n % 2) == 0);
      end
      if (seen_aw !== ((n % 2) == 1)) begin
        errors++; $display("FAIL collision_a_wait n=%0d: got %b expected %b", n, seen_aw, (n % 2) == 1);
      end
    end
    idle();
    drive(1'b0, 1'b1, 1'b0, 6'd2, '0, '0);
    step();
    idle();
    for (int i = 0; i < 4; i++) step();
    checks += 3;
    if (dut_a_done - a0 !== 2 || dut_b_done - b0 !== 2) begin
      errors++; $display("FAIL collision_done: got a=%0d b=%0d expected 2/2", dut_a_done - a0, dut_b_done - b0);
    end
    if (obs_a_data !== 32'h000000B3) begin
      errors++; $display("FAIL collision_final: got %h expected 000000b3", obs_a_data);
    end
    if (m_prio !== 1'b0) begin
      errors++; $display("FAIL collision_model_prio: got %b expected 0", m_prio);
    end
  endtask

  task automatic test_cross_rdw();
    logic [31:0] exp;
`ifdef AVALON_DPRAM_BYPASS_EN
    exp = 32'h00000055;
`else
    exp = 32'h12345678;
`endif
    drive(1'b0, 1'b0, 1'b1, 6'd3, 32'h12345678, 4'hf);
    step();
    drive(1'b0, 1'b1, 1'b0, 6'd3, '0, '0);
    drive(1'b1, 1'b0, 1'b1, 6'd3, 32'h00000055, 4'hf);
    step();
    idle();
    drive(1'b1, 1'b1, 1'b0, 6'd3, '0, '0);
    step();
    idle();
    for (int i = 0; i < 4; i++) step();
    checks += 2;
    if (obs_a_data !== exp) begin
      errors++; $display("FAIL cross_rdw: got %h expected %h", obs_a_data, exp);
    end
    if (obs_b_data !== 32'h00000055) begin
      errors++; $display("FAIL cross_after: got %h expected 00000055", obs_b_data);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 1'($urandom), 1'($urandom), 6'($urandom_range(0, 7)), $urandom, 4'($urandom));
      drive(1'b1, 1'($urandom), 1'($urandom), 6'($urandom_range(0, 7)), $urandom, 4'($urandom));
      step();
    end
    idle();
    for (int i = 0; i < 5; i++) step();
  endtask

  task automatic test_reset_inflight();
    int na, nb;
    drive(1'b0, 1'b1, 1'b0, 6'd9, '0, '0);
    drive(1'b1, 1'b1, 1'b0, 6'd3, '0, '0);
    step();
    idle();
    for (int i = 0; i < 4; i++) step();
    drive(1'b0, 1'b1, 1'b0, 6'd5, '0, '0);
    drive(1'b1, 1'b1, 1'b0, 6'd9, '0, '0);
    step();
    step();
    idle();
    areset_n = 1'b0;
    #1;
    checks += 4;
    if (a_if.readdata !== '0) begin
      errors++; $display("FAIL rst_async_a_data: got %h expected 0", a_if.readdata);
    end
    if (a_if.readdatavalid !== 1'b0) begin
      errors++; $display("FAIL rst_async_a_valid: got %b expected 0", a_if.readdatavalid);
    end
    if (b_if.readdata !== '0) begin
      errors++; $display("FAIL rst_async_b_data: got %h expected 0", b_if.readdata);
    end
    if (b_if.readdatavalid !== 1'b0) begin
      errors++; $display("FAIL rst_async_b_valid: got %b expected 0", b_if.readdatavalid);
    end
    qa.delete();
    qb.delete();
    exp_last_a = '0;
    exp_last_b = '0;
    m_prio     = 1'b0;
    @(posedge clock); @(posedge clock);
    #1;
    areset_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    drive(1'b0, 1'b0, 1'b1, 6'd20, 32'h0000AAAA, 4'hf);
    drive(1'b1, 1'b0, 1'b1, 6'd20, 32'h0000BBBB, 4'hf);
    step();
    checks++;
    if (seen_bw !== 1'b1 || seen_aw !== 1'b0) begin
      errors++; $display("FAIL rst_prio: got a_wait=%b b_wait=%b expected 0/1", seen_aw, seen_bw);
    end
    idle();
    step();
  endtask

  initial begin
    idle();
    test_reset();
    test_fill();
    test_latency();
    test_back_to_back();
    test_byteenable();
    test_collision();
    test_cross_rdw();
    test_random();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
